// File: rtl/tone_gen.sv
// tone_gen: eight-note (C4..C5) square-wave speaker driver; speaker rises 1 cycle after switch is seen high, notes change only at half-period edges.
// No backpressure, output is free-running; defining TONE_OCTAVE_EN adds the octave port (half-period << octave).
module tone_gen #(
    parameter int CLK_MHZ = 20,
    parameter int CNT_W   = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch,
    input  logic [2:0] note,
    input  logic       note_valid,
`ifdef TONE_OCTAVE_EN
    input  logic [1:0] octave,
`endif
    output logic       speaker,
    output logic       playing
);

    typedef enum logic [1:0] {IDLE, PLAY, STOP} state_t;

    function automatic logic [CNT_W-1:0] hp_of(input logic [2:0] n, input logic [1:0] oct);
        int base;
        case (n)
            3'd0:    base = 1911;
            3'd1:    base = 1703;
            3'd2:    base = 1517;
            3'd3:    base = 1432;
            3'd4:    base = 1276;
            3'd5:    base = 1136;
            3'd6:    base = 1012;
            default: base = 956;
        endcase
        return CNT_W'(CLK_MHZ * base) << oct;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             flip_q, flip_d;
    logic [2:0]       pend_note_q, pend_note_d;
    logic [1:0]       pend_oct_d;
    logic             toggle;

`ifdef TONE_OCTAVE_EN
    logic [1:0]       pend_oct_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_oct_q <= 2'd0;
        end else begin
            pend_oct_q <= pend_oct_d;
        end
    end
`endif

    assign toggle = (state_q != IDLE) && (cnt_q == hp_q - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (switch) state_d = PLAY;
            PLAY: if (!switch) state_d = STOP;
            STOP: begin
                if (switch) begin
                    state_d = PLAY;
                end else if (toggle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: a pending write on the toggle cycle bypasses straight into hp
    always_comb begin
        pend_note_d = note_valid ? note : pend_note_q;
`ifdef TONE_OCTAVE_EN
        pend_oct_d  = note_valid ? octave : pend_oct_q;
`else
        pend_oct_d  = 2'd0;
`endif
        cnt_d  = cnt_q;
        flip_d = flip_q;
        hp_d   = hp_q;
        if (state_q == IDLE) begin
            cnt_d  = '0;
            flip_d = 1'b0;
            if (switch) begin
                flip_d = 1'b1;
                hp_d   = hp_of(pend_note_d, pend_oct_d);
            end
        end else if (toggle) begin
            cnt_d  = '0;
            flip_d = (state_d == IDLE) ? 1'b0 : ~flip_q;
            hp_d   = hp_of(pend_note_d, pend_oct_d);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            flip_q      <= 1'b0;
            pend_note_q <= 3'd5;
            hp_q        <= hp_of(3'd5, 2'd0);
        end else begin
            cnt_q       <= cnt_d;
            flip_q      <= flip_d;
            pend_note_q <= pend_note_d;
            hp_q        <= hp_d;
        end
    end

    // Outputs
    always_comb begin
        playing = (state_q != IDLE);
        speaker = (state_q != IDLE) ? flip_q : 1'b0;
    end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen at CLK_MHZ=1: a monitor records every speaker run (level, length) and each scenario pushes expected runs.
module tb_tone_gen;
    localparam int CLK_MHZ = 1;
    localparam int CNT_W   = 21;

    typedef struct packed {
        logic        lvl;
        logic [30:0] len;
    } run_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       switch = 1'b0;
    logic       note_valid = 1'b0;
    logic [2:0] note = 3'd0;
`ifdef TONE_OCTAVE_EN
    logic [1:0] octave = 2'd0;
`endif
    logic       speaker;
    logic       playing;

    int   hp_tab [8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};
    run_t obs_q [$];
    run_t exp_q [$];
    int   rd_idx  = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   dead    = 1'b0;
    bit   mon_en  = 1'b0;
    logic mon_lvl = 1'b0;
    int   mon_len = 0;

    always #5 clk = ~clk;

    tone_gen #(.CLK_MHZ(CLK_MHZ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .switch     (switch),
        .note       (note),
        .note_valid (note_valid),
`ifdef TONE_OCTAVE_EN
        .octave     (octave),
`endif
        .speaker    (speaker),
        .playing    (playing)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (speaker !== mon_lvl) begin
                obs_q.push_back({mon_lvl, 31'(mon_len)});
                mon_lvl = speaker;
                mon_len = 1;
            end else begin
                mon_len = mon_len + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the negedge on which the next run was recorded.
    task automatic wait_obs(output bit ok);
        int n = 0;
        if (!dead) begin
            while (obs_q.size() <= rd_idx && n < 40000) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        ok = (obs_q.size() > rd_idx);
        if (!ok) dead = 1'b1;
    endtask

    task automatic skip_obs(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            bit k;
            wait_obs(k);
            if (k) rd_idx++;
            else   ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        #1;
        n_cmp++;
        if (speaker !== 1'b0) begin n_err++; $display("FAIL reset_speaker: got %b, required 0", speaker); end
        n_cmp++;
        if (playing !== 1'b0) begin n_err++; $display("FAIL reset_playing: got %b, required 0", playing); end
        rst = 1'b0;
        mon_en = 1'b1;
        tick(20);
        n_cmp++;
        if (obs_q.size() != 0 || speaker !== 1'b0) begin
            n_err++; $display("FAIL idle_quiet: got %0d edges speaker=%b, required 0 edges speaker=0", obs_q.size(), speaker);
        end
    endtask

    task automatic test_play();
        bit ok;
        tick(1);
        switch = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (speaker !== 1'b0) begin n_err++; $display("FAIL start_early: got %b, required 0", speaker); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (speaker !== 1'b1) begin n_err++; $display("FAIL start_latency: got %b, required 1", speaker); end
        n_cmp++;
        if (playing !== 1'b1) begin n_err++; $display("FAIL play_playing: got %b, required 1", playing); end
        skip_obs(1, ok);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'(~i[0]), 31'(CLK_MHZ * 1136)});
        while (exp_q.size() > 0) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL play_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL play_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
        end
    endtask

    task automatic test_note_change();
        int   order [7] = '{0, 1, 2, 3, 4, 6, 7};
        int   cur = CLK_MHZ * 1136;
        logic lvl = 1'b1;
        bit   ok;
        for (int i = 0; i <= 7; i++) begin
            run_t e, g;
            if (i < 7) begin
                tick(10);
                note = 3'(order[i]);
                note_valid = 1'b1;
                tick(1);
                note_valid = 1'b0;
            end
            exp_q.push_back({lvl, 31'(cur)});
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL note_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL note_run %0d: got lvl=%0d len=%0d, required lvl=%0d len=%0d", i, g.lvl, g.len, e.lvl, e.len); end
            end
            lvl = ~lvl;
            if (i < 7) cur = CLK_MHZ * hp_tab[order[i]];
        end
    endtask

    // Strobe lands exactly on the toggle cycle of a C5 high phase.
    task automatic test_bypass();
        bit ok;
        tick(CLK_MHZ * 956 - 1);
        note = 3'd5;
        note_valid = 1'b1;
        tick(1);
        note_valid = 1'b0;
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 956)});
        exp_q.push_back({1'b0, 31'(CLK_MHZ * 1136)});
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        while (exp_q.size() > 0) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL bypass_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL bypass_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
        end
    endtask

    task automatic test_stop_high();
        bit ok;
        exp_q.push_back({1'b0, 31'(CLK_MHZ * 1136)});
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        for (int i = 0; i < 2; i++) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL stop_high_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL stop_high_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
            if (i == 0) begin
                tick(299);
                switch = 1'b0;
                tick(1);
                n_cmp++;
                if (playing !== 1'b1) begin n_err++; $display("FAIL stop_pending_playing: got %b, required 1", playing); end
            end
        end
        n_cmp++;
        if (playing !== 1'b0) begin n_err++; $display("FAIL stop_high_idle: playing got %b, required 0", playing); end
        tick(2500);
        n_cmp++;
        if (obs_q.size() != rd_idx || speaker !== 1'b0) begin
            n_err++; $display("FAIL stop_high_quiet: got %0d extra edges speaker=%b, required 0 speaker=0", obs_q.size() - rd_idx, speaker);
        end
    endtask

    task automatic test_stop_low();
        bit   ok;
        int   n = 0;
        run_t e, g;
        tick(1);
        switch = 1'b1;
        skip_obs(1, ok);
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        wait_obs(ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL stop_low_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
        end else begin
            g = obs_q[rd_idx];
            rd_idx++;
            if (g !== e) begin n_err++; $display("FAIL stop_low_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
        end
        tick(100);
        switch = 1'b0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (playing === 1'b1 && n < 5000);
        n_cmp++;
        if (n != CLK_MHZ * 1136 - 100 + 1) begin n_err++; $display("FAIL stop_low_latency: got %0d cycles, required %0d", n, CLK_MHZ * 1136 - 99); end
        tick(1500);
        n_cmp++;
        if (obs_q.size() != rd_idx || speaker !== 1'b0) begin
            n_err++; $display("FAIL stop_low_quiet: got %0d extra edges speaker=%b, required 0 speaker=0", obs_q.size() - rd_idx, speaker);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        tick(1);
        switch = 1'b1;
        skip_obs(1, ok);
        tick(200);
        switch = 1'b0;
        tick(100);
        switch = 1'b1;
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        exp_q.push_back({1'b0, 31'(CLK_MHZ * 1136)});
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        while (exp_q.size() > 0) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL resume_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL resume_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
        end
        n_cmp++;
        if (playing !== 1'b1) begin n_err++; $display("FAIL resume_playing: got %b, required 1", playing); end
    endtask

    // Pending C5 is written just before reset; reset must bring back A4.
    task automatic test_rst_mid();
        bit ok;
        skip_obs(1, ok);
        tick(400);
        note = 3'd7;
        note_valid = 1'b1;
        tick(1);
        note_valid = 1'b0;
        tick(1);
        rst = 1'b1;
        switch = 1'b0;
        tick(1);
        n_cmp++;
        if (speaker !== 1'b0 || playing !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: got speaker=%b playing=%b, required 0 0", speaker, playing);
        end
        rst = 1'b0;
        switch = 1'b1;
        skip_obs(2, ok);
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1136)});
        exp_q.push_back({1'b0, 31'(CLK_MHZ * 1136)});
        while (exp_q.size() > 0) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL rst_resume_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL rst_resume_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
        end
    endtask

`ifdef TONE_OCTAVE_EN
    task automatic test_octave();
        bit ok;
        int n = 0;
        switch = 1'b0;
        while (playing === 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (playing !== 1'b0) begin n_err++; $display("FAIL octave_idle: playing got %b, required 0", playing); end
        tick(2);
        rd_idx = obs_q.size();
        note = 3'd0;
        octave = 2'd3;
        note_valid = 1'b1;
        tick(1);
        note_valid = 1'b0;
        switch = 1'b1;
        skip_obs(1, ok);
        exp_q.push_back({1'b1, 31'(CLK_MHZ * 1911 * 8)});
        exp_q.push_back({1'b0, 31'(CLK_MHZ * 1911 * 8)});
        while (exp_q.size() > 0) begin
            run_t e, g;
            wait_obs(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL octave_run: no edge, required lvl=%0d len=%0d", e.lvl, e.len);
            end else begin
                g = obs_q[rd_idx];
                rd_idx++;
                if (g !== e) begin n_err++; $display("FAIL octave_run: got lvl=%0d len=%0d, required lvl=%0d len=%0d", g.lvl, g.len, e.lvl, e.len); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_play();
        test_note_change();
        test_bypass();
        test_stop_high();
        test_stop_low();
        test_back_to_back();
        test_rst_mid();
`ifdef TONE_OCTAVE_EN
        test_octave();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
